cylon_sequencer: RTL and testbench

//   Control/sequencing front end for the cylon LED sweep. Conditions btnC/btnL/btnR,

---
 rtl/cylon_pkg.sv | 25 ++
 rtl/btn_debounce.sv | 54 +++++
 rtl/cylon_sequencer.sv | 143 ++++++++++++++
 tb/tb_cylon_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cylon_pkg.sv
// Shared types and constants for the cylon sweep sequencer.
package cylon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_e;

    localparam int unsigned SPEED_W = 3;
    localparam logic [SPEED_W-1:0] SPEED_MAX = 3'd7;
    localparam int unsigned PRESC_W = 28;

    // Step period for a speed level; never returns 0 so the prescaler always wraps.
    function automatic logic [PRESC_W-1:0] step_period(input logic [PRESC_W-1:0] base,
                                                       input logic [SPEED_W-1:0] spd);
        logic [PRESC_W-1:0] p;
        p = base >> spd;
        if (p == '0) begin
            p = PRESC_W'(1);
        end
        return p;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter and press pulse.
module btn_debounce #(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic press_o
);

    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic        level_q, level_d;
    logic        press_q, press_d;
    logic [19:0] cnt_q, cnt_d;

    // Count consecutive synchronised samples that disagree with the accepted level.
    always_comb begin
        sync1_d = btn_i;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == DEBOUNCE_CYCLES - 20'd1) begin
            level_d = sync2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 20'd1;
        end
        // Only the accepted rising edge produces an event.
        press_d = level_d & ~level_q;
    end

    // State registers; reset leaves the button released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/cylon_sequencer.sv
// Cylon sweep front end: mode FSM, speed select, step prescaler and bouncing position.
module cylon_sequencer
    import cylon_pkg::*;
#(
    parameter logic [27:0] CLOCK_CYCLES_PER_PULSE = 28'd50_000_000,
    parameter logic [19:0] DEBOUNCE_CYCLES        = 20'd1_000_000,
    parameter int unsigned NUM_LEDS               = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         btnC,
    input  logic         btnL,
    input  logic         btnR,
    output logic         running,
    output logic [2:0]   speed,
    output logic         step,
    output logic         dir,
    output logic [3:0]   pos
);

    localparam logic [3:0] POS_LAST   = 4'(NUM_LEDS - 1);
    localparam logic [3:0] POS_PENULT = 4'(NUM_LEDS - 2);

    logic ev_c, ev_l, ev_r;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_c (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_i  (btnC),
        .press_o(ev_c)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_l (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_i  (btnL),
        .press_o(ev_l)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_r (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_i  (btnR),
        .press_o(ev_r)
    );

    state_e               state_q, state_d;
    logic [SPEED_W-1:0]   speed_q, speed_d;
    logic [PRESC_W-1:0]   cnt_q, cnt_d;
    logic [PRESC_W-1:0]   period;
    logic                 step_q, step_d;
    logic                 dir_q, dir_d;
    logic [3:0]           pos_q, pos_d;

    assign period = step_period(CLOCK_CYCLES_PER_PULSE, speed_q);

    // Mode FSM: C toggles run/pause, L+R together abort to idle from anywhere.
    always_comb begin
        state_d = state_q;
        if (ev_l && ev_r) begin
            state_d = IDLE;
        end else if (ev_c) begin
            unique case (state_q)
                IDLE:    state_d = RUN;
                RUN:     state_d = PAUSE;
                PAUSE:   state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    // Speed, prescaler and bouncing position; counting uses the current mode.
    always_comb begin
        speed_d = speed_q;
        cnt_d   = cnt_q;
        pos_d   = pos_q;
        dir_d   = dir_q;
        step_d  = 1'b0;
        if (ev_l && ev_r) begin
            cnt_d = '0;
            pos_d = '0;
            dir_d = 1'b0;
        end else begin
            if (ev_r && speed_q != SPEED_MAX) begin
                speed_d = speed_q + 3'd1;
            end else if (ev_l && speed_q != '0) begin
                speed_d = speed_q - 3'd1;
            end
            if (speed_d != speed_q) begin
                // New period: restart the count so it never sits above period-1.
                cnt_d = '0;
            end else if (state_q == RUN) begin
                if (cnt_q >= period - PRESC_W'(1)) begin
                    cnt_d  = '0;
                    step_d = 1'b1;
                    if (!dir_q) begin
                        if (pos_q == POS_LAST) begin
                            dir_d = 1'b1;
                            pos_d = POS_PENULT;
                        end else begin
                            pos_d = pos_q + 4'd1;
                        end
                    end else begin
                        if (pos_q == '0) begin
                            dir_d = 1'b0;
                            pos_d = 4'd1;
                        end else begin
                            pos_d = pos_q - 4'd1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + PRESC_W'(1);
                end
            end
        end
    end

    // All state and outputs registered; reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            speed_q <= '0;
            cnt_q   <= '0;
            step_q  <= 1'b0;
            dir_q   <= 1'b0;
            pos_q   <= '0;
        end else begin
            state_q <= state_d;
            speed_q <= speed_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            dir_q   <= dir_d;
            pos_q   <= pos_d;
        end
    end

    assign running = (state_q == RUN);
    assign speed   = speed_q;
    assign step    = step_q;
    assign dir     = dir_q;
    assign pos     = pos_q;

endmodule

// File: tb/tb_cylon_sequencer.sv
// Directed bench for cylon_sequencer with a per-cycle behavioural reference model.
module tb_cylon_sequencer;

    localparam int CCP = 500;
    localparam int DB  = 4;
    localparam int N   = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       btnC = 1'b0;
    logic       btnL = 1'b0;
    logic       btnR = 1'b0;
    logic       running;
    logic [2:0] speed;
    logic       step;
    logic       dir;
    logic [3:0] pos;

    cylon_sequencer #(
        .CLOCK_CYCLES_PER_PULSE(28'(CCP)),
        .DEBOUNCE_CYCLES       (20'(DB)),
        .NUM_LEDS              (N)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .btnC   (btnC),
        .btnL   (btnL),
        .btnR   (btnR),
        .running(running),
        .speed  (speed),
        .step   (step),
        .dir    (dir),
        .pos    (pos)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int steps_seen = 0;
    bit chk_on = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (step === 1'b1) steps_seen <= steps_seen + 1;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: mode 0=idle 1=run 2=pause; position derived from total step count.
    int m_mode, m_speed, m_cnt, m_steps;
    bit m_step;
    bit [15:0] m_hist [3];
    bit m_lvl [3];
    bit m_pend [3];

    function automatic int exp_pos(input int s);
        int f;
        if (s == 0) return 0;
        f = s % (2 * N - 2);
        return (f < N) ? f : 2 * N - 2 - f;
    endfunction

    function automatic int exp_dir(input int s);
        int f;
        if (s == 0) return 0;
        f = s % (2 * N - 2);
        return (f >= N || f == 0) ? 1 : 0;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_speed = 0; m_cnt = 0; m_steps = 0; m_step = 0;
        for (int b = 0; b < 3; b++) begin
            m_hist[b] = '0; m_lvl[b] = 0; m_pend[b] = 0;
        end
    endtask

    task automatic model_edge();
        bit ev [3];
        bit raw [3];
        int per, ns;
        bit all_diff;
        raw[0] = btnC; raw[1] = btnL; raw[2] = btnR;
        for (int b = 0; b < 3; b++) ev[b] = m_pend[b];
        per = CCP >> m_speed;
        if (per == 0) per = 1;
        m_step = 0;
        if (ev[1] && ev[2]) begin
            m_mode = 0; m_cnt = 0; m_steps = 0;
        end else begin
            ns = m_speed;
            if (ev[2]) ns = (m_speed < 7) ? m_speed + 1 : 7;
            else if (ev[1]) ns = (m_speed > 0) ? m_speed - 1 : 0;
            if (ns != m_speed) begin
                m_speed = ns; m_cnt = 0;
            end else if (m_mode == 1) begin
                if (m_cnt == per - 1) begin
                    m_step = 1; m_cnt = 0; m_steps++;
                end else begin
                    m_cnt++;
                end
            end
            if (ev[0]) m_mode = (m_mode == 1) ? 2 : 1;
        end
        // A button is accepted once the last DB samples (2 cycles late) all differ from it.
        for (int b = 0; b < 3; b++) begin
            m_hist[b] = {m_hist[b][14:0], raw[b]};
            all_diff = 1;
            for (int k = 2; k < DB + 2; k++) if (m_hist[b][k] == m_lvl[b]) all_diff = 0;
            m_pend[b] = 0;
            if (all_diff) begin
                m_lvl[b] = ~m_lvl[b];
                m_pend[b] = m_lvl[b];
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst_n) model_reset();
            else model_edge();
        end
    end

    // Compare every cycle outside reset.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_on && rst_n) begin
                check("model_running", int'(running), int'(m_mode == 1));
                check("model_speed", int'(speed), m_speed);
                check("model_step", int'(step), int'(m_step));
                check("model_pos", int'(pos), exp_pos(m_steps));
                check("model_dir", int'(dir), exp_dir(m_steps));
            end
        end
    end

    task automatic set_btn(input int b, input logic v);
        case (b)
            0: btnC = v;
            1: btnL = v;
            default: btnR = v;
        endcase
    endtask

    task automatic press(input int b);
        @(negedge clk);
        set_btn(b, 1'b1);
        repeat (10) @(negedge clk);
        set_btn(b, 1'b0);
        repeat (10) @(negedge clk);
    endtask

    task automatic wait_step(input int max, output int t);
        bit ok;
        ok = 0;
        t = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (step === 1'b1) begin
                ok = 1;
                t = cyc;
                break;
            end
        end
        if (!ok) check("step_timeout", 0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, t_run, t1, t2, t0, pos_p, seen_p;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk_on = 1'b1;

        // 1. Idle with no buttons.
        repeat (5000) @(negedge clk);
        check("idle_running", int'(running), 0);
        check("idle_speed", int'(speed), 0);
        check("idle_pos", int'(pos), 0);
        check("idle_dir", int'(dir), 0);
        check("idle_no_step", steps_seen, 0);

        // 2. Start: 7-cycle latency, first step one period later.
        @(negedge clk);
        btnC = 1'b1;
        lat = 0;
        t_run = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (running && lat == 0) begin
                lat = i;
                t_run = cyc;
            end
        end
        @(negedge clk);
        btnC = 1'b0;
        check("start_latency", lat, 7);
        wait_step(600, t1);
        check("first_step_delay", t1 - t_run, 500);
        check("first_step_pos", int'(pos), 1);

        // 3. Bounce at both ends.
        repeat (14) wait_step(600, t1);
        check("top_pos", int'(pos), 15);
        check("top_dir", int'(dir), 0);
        wait_step(600, t1);
        check("turn_down_pos", int'(pos), 14);
        check("turn_down_dir", int'(dir), 1);
        repeat (14) wait_step(600, t1);
        check("bottom_pos", int'(pos), 0);
        check("bottom_dir", int'(dir), 1);
        wait_step(600, t1);
        check("turn_up_pos", int'(pos), 1);
        check("turn_up_dir", int'(dir), 0);
        check("single_start_event", int'(running), 1);

        // 4. Speed control and period scaling.
        repeat (3) press(2);
        check("speed3", int'(speed), 3);
        wait_step(200, t1);
        wait_step(200, t2);
        check("spacing_speed3", t2 - t1, 62);
        repeat (5) press(2);
        check("speed7", int'(speed), 7);
        wait_step(50, t1);
        wait_step(50, t2);
        check("spacing_speed7", t2 - t1, 3);
        repeat (8) press(1);
        check("speed0_sat", int'(speed), 0);

        // 5. Pause mid-period, resume with the remaining count, then abort to idle.
        wait_step(600, t1);
        repeat (200) @(negedge clk);
        btnC = 1'b1;
        repeat (10) @(negedge clk);
        btnC = 1'b0;
        repeat (20) @(negedge clk);
        check("paused", int'(running), 0);
        pos_p = int'(pos);
        seen_p = steps_seen;
        repeat (1000) @(negedge clk);
        check("pause_pos_frozen", int'(pos), pos_p);
        check("pause_no_step", steps_seen, seen_p);
        t0 = cyc;
        btnC = 1'b1;
        repeat (10) @(negedge clk);
        btnC = 1'b0;
        wait_step(600, t1);
        check("resume_remaining", t1 - t0, 300);
        press(2);
        check("speed1", int'(speed), 1);
        @(negedge clk);
        btnL = 1'b1;
        btnR = 1'b1;
        repeat (10) @(negedge clk);
        btnL = 1'b0;
        btnR = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_running", int'(running), 0);
        check("abort_pos", int'(pos), 0);
        check("abort_dir", int'(dir), 0);
        check("abort_speed_kept", int'(speed), 1);

        // 6. Glitch rejection and asynchronous reset mid-run.
        @(negedge clk);
        btnC = 1'b1;
        repeat (2) @(negedge clk);
        btnC = 1'b0;
        repeat (50) @(negedge clk);
        check("glitch_ignored", int'(running), 0);
        press(0);
        check("restart", int'(running), 1);
        repeat (600) @(negedge clk);
        check("run_pos_speed1", int'(pos), 2);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", int'({running, speed, step, dir, pos}), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check("post_reset_idle", int'(running), 0);
        check("post_reset_pos", int'(pos), 0);
        check("post_reset_speed", int'(speed), 0);

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
